// File: rtl/serial_adder_n.sv
// serial_adder_n: multi-cycle adder that adds DIGIT bits of a+b+cin per clock.
// A carry flop links consecutive slices, and a start/busy/done handshake frames
// each operation. N = WIDTH/DIGIT slices give a result N edges after accept.
// Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] res_next;
`ifdef SERIAL_ADDER_OVF_EN
    logic             msb_cin;
`endif

    // Slice adder on the low operand digits. The new digit enters the result
    // register at the MSB end, so after N slices the first digit sits at bit 0.
    always_comb begin
        slice    = {1'b0, a_sr[DIGIT-1:0]} + {1'b0, b_sr[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
        res_next = (res_sr >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
`ifdef SERIAL_ADDER_OVF_EN
        // Carry into the MSB: recover it from the MSB sum bit and the MSB operand bits.
        msb_cin  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ slice[DIGIT-1];
`endif
    end

    // Control FSM and datapath. Results are published only at completion,
    // so sum/cout keep the previous answer throughout RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr   <= a;
                        b_sr   <= b;
                        carry  <= cin;
                        res_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    carry  <= slice[DIGIT];
                    res_sr <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf   <= msb_cin ^ slice[DIGIT];
`endif
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n: four instances cover DIGIT=1, 2 (WIDTH=4),
// WIDTH and 4, plus signed overflow when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_n;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // WIDTH=8 DIGIT=1
    logic       p_start, p_cin, p_busy, p_done, p_cout;
    logic [7:0] p_a, p_b, p_sum;
    // WIDTH=4 DIGIT=2
    logic       q_start, q_cin, q_busy, q_done, q_cout;
    logic [3:0] q_a, q_b, q_sum;
    // WIDTH=8 DIGIT=8
    logic       r_start, r_cin, r_busy, r_done, r_cout;
    logic [7:0] r_a, r_b, r_sum;
    // WIDTH=8 DIGIT=4
    logic       v_start, v_cin, v_busy, v_done, v_cout;
    logic [7:0] v_a, v_b, v_sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic       p_ovf, q_ovf, r_ovf, v_ovf;
`endif

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_p (
        .clk(clk), .rst_n(rst_n), .start(p_start), .a(p_a), .b(p_b), .cin(p_cin),
        .busy(p_busy), .done(p_done), .sum(p_sum), .cout(p_cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(p_ovf)
`endif
    );
    serial_adder_n #(.WIDTH(4), .DIGIT(2)) u_q (
        .clk(clk), .rst_n(rst_n), .start(q_start), .a(q_a), .b(q_b), .cin(q_cin),
        .busy(q_busy), .done(q_done), .sum(q_sum), .cout(q_cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(q_ovf)
`endif
    );
    serial_adder_n #(.WIDTH(8), .DIGIT(8)) u_r (
        .clk(clk), .rst_n(rst_n), .start(r_start), .a(r_a), .b(r_b), .cin(r_cin),
        .busy(r_busy), .done(r_done), .sum(r_sum), .cout(r_cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(r_ovf)
`endif
    );
    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_v (
        .clk(clk), .rst_n(rst_n), .start(v_start), .a(v_a), .b(v_b), .cin(v_cin),
        .busy(v_busy), .done(v_done), .sum(v_sum), .cout(v_cout)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(v_ovf)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one add on the DIGIT=1 instance; lat = edges from accept to done.
    task automatic op_p(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat, output int nbusy);
        p_start = 1'b1; p_a = a; p_b = b; p_cin = c;
        @(posedge clk); #1;
        p_start = 1'b0; p_a = ~a; p_b = ~b; p_cin = ~c;
        lat = 0; nbusy = 0;
        while (!p_done && lat < 100) begin
            if (p_busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_r(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        r_start = 1'b1; r_a = a; r_b = b; r_cin = c;
        @(posedge clk); #1;
        r_start = 1'b0; r_a = ~a; r_b = ~b; r_cin = ~c;
        lat = 0;
        while (!r_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_v(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        v_start = 1'b1; v_a = a; v_b = b; v_cin = c;
        @(posedge clk); #1;
        v_start = 1'b0; v_a = ~a; v_b = ~b; v_cin = ~c;
        lat = 0;
        while (!v_done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    // Overflow from the top 4-bit slice: carry into it, then carry into bit 7 inside it.
    function automatic logic ovf_model(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [4:0] lo;
        logic [3:0] hi;
        logic [8:0] full;
        lo   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c};
        hi   = {1'b0, a[6:4]} + {1'b0, b[6:4]} + {3'd0, lo[4]};
        full = {1'b0, a} + {1'b0, b} + {8'd0, c};
        return hi[3] ^ full[8];
    endfunction
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tp[7];
        vec_t tv[4];
        int   lat, nb, cnt, idx, cyc, last, ndone, e;

        tp[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tp[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b0};
        tp[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tp[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tp[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
        tp[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        tp[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};

        tv[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tv[1] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        tv[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tv[3] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};

        p_start = 0; p_a = 0; p_b = 0; p_cin = 0;
        q_start = 0; q_a = 0; q_b = 0; q_cin = 0;
        r_start = 0; r_a = 0; r_b = 0; r_cin = 0;
        v_start = 0; v_a = 0; v_b = 0; v_cin = 0;

        // Reset state
        #12;
        chk("rst_busy", {p_busy, q_busy, r_busy, v_busy}, 0);
        chk("rst_done", {p_done, q_done, r_done, v_done}, 0);
        chk("rst_cout", {p_cout, q_cout, r_cout, v_cout}, 0);
        chk("rst_sum_p", p_sum, 0);
        chk("rst_sum_v", v_sum, 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {p_ovf, q_ovf, r_ovf, v_ovf}, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: DIGIT=1, eight slices per add
        for (int i = 0; i < 7; i++) begin
            op_p(tp[i].a, tp[i].b, tp[i].cin, lat, nb);
            chk("p_lat", lat, 8);
            chk("p_busy_cycles", nb, 8);
            chk("p_sum", p_sum, tp[i].sum);
            chk("p_cout", p_cout, tp[i].cout);
            chk("p_busy_at_done", p_busy, 0);
            @(posedge clk); #1;
            chk("p_done_width", p_done, 0);
        end

        // start while busy is ignored; sum holds previous result (0x02) during RUN
        p_start = 1'b1; p_a = 8'h5A; p_b = 8'h3C; p_cin = 1'b1;
        @(posedge clk); #1;
        p_start = 1'b0; lat = 0;
        chk("ign_busy", p_busy, 1);
        chk("ign_hold", p_sum, 8'h02);
        repeat (2) begin @(posedge clk); #1; lat++; end
        p_start = 1'b1; p_a = 8'h00; p_b = 8'h00; p_cin = 1'b0;
        @(posedge clk); #1; lat++;
        p_start = 1'b0;
        chk("ign_busy2", p_busy, 1);
        chk("ign_hold2", p_sum, 8'h02);
        while (!p_done && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("ign_lat", lat, 8);
        chk("ign_sum", p_sum, 8'h97);
        chk("ign_cout", p_cout, 0);
        cnt = 0;
        repeat (10) begin @(posedge clk); #1; if (p_busy || p_done) cnt++; end
        chk("ign_no_queue", cnt, 0);

        // Reset mid-operation
        p_start = 1'b1; p_a = 8'hAA; p_b = 8'h55; p_cin = 1'b1;
        @(posedge clk); #1;
        p_start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_busy", p_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", p_busy, 0);
        chk("mid_rst_done", p_done, 0);
        chk("mid_rst_sum", p_sum, 0);
        chk("mid_rst_cout", p_cout, 0);
        #2 rst_n = 1'b1;
        cnt = 0;
        repeat (12) begin @(posedge clk); #1; if (p_done || p_busy) cnt++; end
        chk("mid_no_done", cnt, 0);
        op_p(8'h01, 8'h01, 1'b0, lat, nb);
        chk("post_rst_lat", lat, 8);
        chk("post_rst_sum", p_sum, 8'h02);
        chk("post_rst_cout", p_cout, 0);

        // DIGIT=WIDTH: registered adder, done one edge after accept
        op_r(8'h80, 8'h80, 1'b0, lat);
        chk("r_lat", lat, 1);
        chk("r_sum", r_sum, 8'h00);
        chk("r_cout", r_cout, 1);
        op_r(8'h3C, 8'h0F, 1'b1, lat);
        chk("r_lat2", lat, 1);
        chk("r_sum2", r_sum, 8'h4C);
        chk("r_cout2", r_cout, 0);

        // DIGIT=4 (and signed overflow when enabled)
        for (int i = 0; i < 4; i++) begin
            op_v(tv[i].a, tv[i].b, tv[i].cin, lat);
            chk("v_lat", lat, 2);
            chk("v_sum", v_sum, tv[i].sum);
            chk("v_cout", v_cout, tv[i].cout);
`ifdef SERIAL_ADDER_OVF_EN
            chk("v_ovf", v_ovf, tv[i].ovf);
            chk("v_ovf_model", v_ovf, ovf_model(tv[i].a, tv[i].b, tv[i].cin));
`endif
        end

        // WIDTH=4 DIGIT=2 exhaustive, back-to-back on each done cycle
        q_a = 4'd0; q_b = 4'd0; q_cin = 1'b0; q_start = 1'b1;
        idx = 0; e = 0;
        @(posedge clk); #1;
        q_start = 1'b0;
        cyc = 0; last = 0; ndone = 0;
        while (ndone < 512 && cyc < 512 * 3 + 50) begin
            @(posedge clk); #1;
            cyc++;
            q_start = 1'b0;
            if (q_done) begin
                chk("x4_sum", {q_cout, q_sum}, e);
                if (ndone > 0) chk("x4_gap", cyc - last, 3);
                last = cyc;
                ndone++;
                idx++;
                if (idx < 512) begin
                    q_a = idx[3:0]; q_b = idx[7:4]; q_cin = idx[8];
                    e = (idx % 16) + ((idx / 16) % 16) + (idx / 256);
                    q_start = 1'b1;
                end
            end
        end
        chk("x4_count", ndone, 512);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
